// File: rtl/sreg_pkg.sv
// Shared definitions for the 42-bit shift-register link (receiver and transmit controller).
package sreg_pkg;
  localparam int SREG_WIDTH = 42;
  localparam int SREG_CNT_W = 6;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_RECV     = 2'd1,
    RX_WAIT_LOW = 2'd2
  } sreg_rx_state_t;
endpackage

// File: rtl/sreg_rx_if.sv
// Serial link inputs plus the parallel valid/ready and status side of the receiver.
interface sreg_rx_if import sreg_pkg::*; #(
  parameter int WIDTH = SREG_WIDTH
);
  logic             sclk;
  logic             sdata;
  logic             shift;
  logic             ready;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             overrun;
  logic             frame_err;
  logic             busy;

  // master: the receiver itself
  modport master (
    input  sclk, sdata, shift, ready, clr_err,
    output data_out, valid, overrun, frame_err, busy
  );

  // slave: link driver plus word consumer
  modport slave (
    output sclk, sdata, shift, ready, clr_err,
    input  data_out, valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/sreg_rx_buf.sv
// One-entry valid/ready holding register; a completed word arriving while full is dropped and flagged.
module sreg_rx_buf #(
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun
);
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             overrun_reg;
  logic             can_load;

  // A consumer draining the entry in the same cycle frees it for the new word
  assign can_load = ~valid_reg | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_en && can_load) begin
        data_reg  <= wr_data;
        valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end

      if (wr_en && !can_load)
        overrun_reg <= 1'b1;
      else if (clr_err)
        overrun_reg <= 1'b0;
    end
  end

  assign data_out = data_reg;
  assign valid    = valid_reg;
  assign overrun  = overrun_reg;
endmodule

// File: rtl/sreg_rx.sv
// Serial-to-parallel receiver: frames LSB-first bits under shift, hands whole words to a one-entry buffer.
module sreg_rx import sreg_pkg::*; #(
  parameter int WIDTH = SREG_WIDTH,
  parameter int CNT_W = SREG_CNT_W
) (
  input  logic      clk,
  input  logic      rst_n,
  sreg_rx_if.master bus
);
  sreg_rx_state_t   state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             sclk_q_reg;
  logic             busy_reg, busy_next;
  logic             frame_err_reg, frame_err_next;
  logic             sclk_rise;
  logic             last_bit;
  logic             wr_en;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] buf_data;
  logic             buf_valid;
  logic             buf_overrun;

  assign sclk_rise = bus.sclk & ~sclk_q_reg;
  assign last_bit  = (bit_cnt_reg == CNT_W'(WIDTH - 1));
  assign word      = {bus.sdata, shreg_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RX_IDLE;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      sclk_q_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      sclk_q_reg    <= bus.sclk;
      busy_reg      <= busy_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:     if (bus.shift) state_next = RX_RECV;
      RX_RECV: begin
        if (!bus.shift)
          state_next = RX_IDLE;
        else if (sclk_rise && last_bit)
          state_next = RX_WAIT_LOW;
      end
      RX_WAIT_LOW: if (!bus.shift) state_next = RX_IDLE;
      default:     state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    shreg_next     = shreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    wr_en          = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        // The edge that coincides with shift rising is already bit 0
        shreg_next   = '0;
        bit_cnt_next = '0;
        if (bus.shift && sclk_rise) begin
          shreg_next   = word;
          bit_cnt_next = CNT_W'(1);
        end
      end
      RX_RECV: begin
        if (!bus.shift) begin
          frame_err_next = 1'b1;
          shreg_next     = '0;
          bit_cnt_next   = '0;
        end else if (sclk_rise) begin
          shreg_next   = word;
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          wr_en        = last_bit;
        end
      end
      RX_WAIT_LOW: if (!bus.shift) bit_cnt_next = '0;
      default: begin
        shreg_next   = '0;
        bit_cnt_next = '0;
      end
    endcase
    busy_next = (state_next == RX_RECV);
  end

  sreg_rx_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (word),
    .ready    (bus.ready),
    .clr_err  (bus.clr_err),
    .data_out (buf_data),
    .valid    (buf_valid),
    .overrun  (buf_overrun)
  );

  assign bus.data_out  = buf_data;
  assign bus.valid     = buf_valid;
  assign bus.overrun   = buf_overrun;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_sreg_rx.sv
// Directed bench for sreg_rx: framing, buffering, overrun, short frames and async reset.
module tb_sreg_rx;
  localparam int W = 42;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sreg_rx_if #(.WIDTH(W)) bus ();

  sreg_rx #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sclk period spans two clk cycles; the rise is seen on the first edge
  task automatic send_bit(input logic b);
    bus.sdata = b;
    bus.sclk  = 1'b1;
    tick();
    bus.sclk  = 1'b0;
    tick();
  endtask

  // Sends a full frame and returns just after the edge detecting the last rise
  task automatic send_frame(input logic [W-1:0] w, input logic exp_valid_before,
                            input logic rdy_last);
    bus.shift = 1'b1;
    for (int i = 0; i < W - 1; i++) send_bit(w[i]);
    check1("valid_before_last", bus.valid, exp_valid_before);
    bus.ready = rdy_last;
    bus.sdata = w[W-1];
    bus.sclk  = 1'b1;
    tick();
    $display("[TB] frame sent %h valid=%b data_out=%h overrun=%b",
             w, bus.valid, bus.data_out, bus.overrun);
  endtask

  task automatic finish_frame();
    bus.sclk  = 1'b0;
    bus.shift = 1'b0;
    tick();
    check1("no_frame_err_at_end", bus.frame_err, 1'b0);
    tick();
  endtask

  task automatic consume();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.sclk    = 1'b0;
    bus.sdata   = 1'b0;
    bus.shift   = 1'b0;
    bus.ready   = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) tick();
    checkw("rst_data", bus.data_out, '0);
    check1("rst_valid", bus.valid, 1'b0);
    check1("rst_overrun", bus.overrun, 1'b0);
    check1("rst_frame_err", bus.frame_err, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic frame with consumer ready
    bus.ready = 1'b1;
    send_frame(42'h2A_5555_AAAA, 1'b0, 1'b1);
    check1("t1_valid", bus.valid, 1'b1);
    checkw("t1_data", bus.data_out, 42'h2A_5555_AAAA);
    check1("t1_overrun", bus.overrun, 1'b0);
    check1("t1_busy_wait", bus.busy, 1'b0);
    finish_frame();
    check1("t1_valid_drained", bus.valid, 1'b0);

    // Back-to-back frames with consumer stalled
    bus.ready = 1'b0;
    send_frame(42'h1, 1'b0, 1'b0);
    checkw("t2_data1", bus.data_out, 42'h1);
    check1("t2_overrun1", bus.overrun, 1'b0);
    finish_frame();
    send_frame(42'h3FF_FFFF_FFFF, 1'b1, 1'b0);
    check1("t2_overrun2", bus.overrun, 1'b1);
    check1("t2_valid2", bus.valid, 1'b1);
    checkw("t2_data_held", bus.data_out, 42'h1);
    finish_frame();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check1("t2_overrun_cleared", bus.overrun, 1'b0);
    consume();
    check1("t2_valid_consumed", bus.valid, 1'b0);
    checkw("t2_data_after_consume", bus.data_out, 42'h1);

    // Short frame: shift dropped after 20 bits
    bus.ready = 1'b1;
    bus.shift = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    check1("t3_busy", bus.busy, 1'b1);
    bus.shift = 1'b0;
    tick();
    $display("[TB] short frame dropped after 20 bits frame_err=%b", bus.frame_err);
    check1("t3_frame_err", bus.frame_err, 1'b1);
    check1("t3_busy_low", bus.busy, 1'b0);
    check1("t3_valid", bus.valid, 1'b0);
    tick();
    check1("t3_frame_err_pulse", bus.frame_err, 1'b0);
    send_frame(42'h0F0F0F0F0F, 1'b0, 1'b1);
    checkw("t3_data_next", bus.data_out, 42'h0F0F0F0F0F);
    check1("t3_valid_next", bus.valid, 1'b1);
    finish_frame();

    // Completion coincides with the prior word being consumed
    bus.ready = 1'b0;
    send_frame(42'h123, 1'b0, 1'b0);
    finish_frame();
    send_frame(42'h3_0000_0456, 1'b1, 1'b1);
    bus.ready = 1'b0;
    checkw("t4_data", bus.data_out, 42'h3_0000_0456);
    check1("t4_valid", bus.valid, 1'b1);
    check1("t4_overrun", bus.overrun, 1'b0);
    tick();
    check1("t4_valid_held", bus.valid, 1'b1);
    finish_frame();
    consume();

    // Async reset mid-frame with a pending word and overrun set
    send_frame(42'h2AB, 1'b0, 1'b0);
    finish_frame();
    send_frame(42'h3C3, 1'b1, 1'b0);
    check1("t5_overrun_pre", bus.overrun, 1'b1);
    finish_frame();
    bus.shift = 1'b1;
    for (int i = 0; i < 30; i++) send_bit(1'b1);
    check1("t5_busy_pre", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset at bit 30");
    checkw("t5_rst_data", bus.data_out, '0);
    check1("t5_rst_valid", bus.valid, 1'b0);
    check1("t5_rst_overrun", bus.overrun, 1'b0);
    check1("t5_rst_busy", bus.busy, 1'b0);
    check1("t5_rst_frame_err", bus.frame_err, 1'b0);
    bus.shift = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(42'h155_5555_5555, 1'b0, 1'b1);
    checkw("t5_data_after", bus.data_out, 42'h155_5555_5555);
    check1("t5_valid_after", bus.valid, 1'b1);
    finish_frame();

    // Shift held for 50 sclk rises
    bus.ready = 1'b0;
    send_frame(42'h2_1234_5678, 1'b0, 1'b0);
    checkw("t6_data", bus.data_out, 42'h2_1234_5678);
    bus.sclk = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    $display("[TB] 8 extra bits sent in WAIT_LOW data_out=%h", bus.data_out);
    checkw("t6_data_unchanged", bus.data_out, 42'h2_1234_5678);
    check1("t6_valid", bus.valid, 1'b1);
    check1("t6_overrun", bus.overrun, 1'b0);
    check1("t6_busy", bus.busy, 1'b0);
    check1("t6_frame_err", bus.frame_err, 1'b0);
    finish_frame();
    check1("t6_valid_end", bus.valid, 1'b1);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
